// File: rtl/uart_reg_ctrl.sv
// ============================================================================
// uart_reg_ctrl
//   16550-style register controller for the UART core. It sits between the
//   host register bus and the TX/RX FIFOs and shift engines. It holds the
//   register map, including the divisor latch (DLAB), the sticky line and
//   modem status bits with clear-on-read, the prioritised IIR and the IRQ.
//
//   Optional feature macro: UART_SCRATCH_EN
//     defined   : address 7 is an 8-bit read/write scratch register (reset 0x00)
//     undefined : address 7 reads 0x00 and writes to it are ignored
//
// Parameters
//   DATA_W      register / character data width (8 for the 16550 map)
//   DIV_W       baud divisor width, 9..16; DLL = div[7:0], DLM = div[DIV_W-1:8]
//   FIFO_DEPTH  RX FIFO depth; the trigger level saturates at this value
//   DIV_RST     divisor reset value (0 is replaced by 1)
//   CNT_W       RX occupancy width, $clog2(FIFO_DEPTH+1)
//
// Ports
//   clk, rst             core clock, asynchronous active-high reset
//   reg_cs/we/addr/wdata single-cycle host register access strobe
//   reg_rdata/rvalid     read data, registered, 1 cycle after the strobe
//   tx_push/tx_wdata     THR write -> TX FIFO push pulse and data
//   tx_empty             TX FIFO and shift register both empty
//   rx_pop               RBR read -> RX FIFO pop pulse
//   rx_rdata/rx_count    RX FIFO head character and occupancy
//   rx_pe/rx_fe/rx_bi    error flags of the RX head character
//   rx_overrun           pulse: a character was lost because the FIFO was full
//   rx_fifo_rst          pulse from FCR[1]
//   tx_fifo_rst          pulse from FCR[2]
//   lcr_o, divisor_o     line control and baud divisor to the framing logic
//   dtr_n, rts_n         modem outputs (inverted MCR[0]/MCR[1])
//   loopback             MCR[4]
//   cts_n, dsr_n         modem inputs, already synchronised
//   irq                  interrupt request, registered
// ============================================================================
module uart_reg_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RST    = 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_cs,
    input  logic              reg_we,
    input  logic [2:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              reg_rvalid,
    output logic              tx_push,
    output logic [DATA_W-1:0] tx_wdata,
    input  logic              tx_empty,
    output logic              rx_pop,
    input  logic [DATA_W-1:0] rx_rdata,
    input  logic [CNT_W-1:0]  rx_count,
    input  logic              rx_pe,
    input  logic              rx_fe,
    input  logic              rx_bi,
    input  logic              rx_overrun,
    output logic              rx_fifo_rst,
    output logic              tx_fifo_rst,
    output logic [7:0]        lcr_o,
    output logic [DIV_W-1:0]  divisor_o,
    output logic              dtr_n,
    output logic              rts_n,
    output logic              loopback,
    input  logic              cts_n,
    input  logic              dsr_n,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;  // RBR / THR / DLL
    localparam logic [2:0] ADDR_IER  = 3'd1;  // IER / DLM
    localparam logic [2:0] ADDR_IIR  = 3'd2;  // IIR (R) / FCR (W)
    localparam logic [2:0] ADDR_LCR  = 3'd3;
    localparam logic [2:0] ADDR_MCR  = 3'd4;
    localparam logic [2:0] ADDR_LSR  = 3'd5;
    localparam logic [2:0] ADDR_MSR  = 3'd6;
    localparam logic [2:0] ADDR_SCR  = 3'd7;

    localparam logic [DIV_W-1:0] DIV_RST_V = (DIV_RST == 0) ? DIV_W'(1) : DIV_W'(DIV_RST);

    localparam logic [3:0] IID_LINE  = 4'h6;
    localparam logic [3:0] IID_RXD   = 4'h4;
    localparam logic [3:0] IID_THRE  = 4'h2;
    localparam logic [3:0] IID_MODEM = 4'h0;
    localparam logic [3:0] IID_NONE  = 4'h1;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [3:0]       ier;
    logic [7:0]       lcr;
    logic [4:0]       mcr;
    logic [1:0]       fcr_trig;
    logic [DIV_W-1:0] divisor;
    logic             oe;          // sticky overrun
    logic             err_fifo;    // sticky "some character carried an error"
    logic             dcts, ddsr;  // sticky modem deltas
    logic             thre_pend;   // THR-empty interrupt pending
    logic             cts_q, dsr_q, tx_empty_q;
    logic [7:0]       scr;

    // ------------------------------------------------------------------
    // Access decode; DLAB steers addresses 0/1 to the divisor latch
    // ------------------------------------------------------------------
    logic dlab, rd, wr;
    logic rd_rbr, wr_thr, wr_dll, wr_dlm, wr_ier, rd_iir, wr_fcr;
    logic wr_lcr, wr_mcr, rd_lsr, rd_msr;

    assign dlab   = lcr[7];
    assign rd     = reg_cs & ~reg_we;
    assign wr     = reg_cs &  reg_we;
    assign rd_rbr = rd & (reg_addr == ADDR_DATA) & ~dlab;
    assign wr_thr = wr & (reg_addr == ADDR_DATA) & ~dlab;
    assign wr_dll = wr & (reg_addr == ADDR_DATA) &  dlab;
    assign wr_dlm = wr & (reg_addr == ADDR_IER)  &  dlab;
    assign wr_ier = wr & (reg_addr == ADDR_IER)  & ~dlab;
    assign rd_iir = rd & (reg_addr == ADDR_IIR);
    assign wr_fcr = wr & (reg_addr == ADDR_IIR);
    assign wr_lcr = wr & (reg_addr == ADDR_LCR);
    assign wr_mcr = wr & (reg_addr == ADDR_MCR);
    assign rd_lsr = rd & (reg_addr == ADDR_LSR);
    assign rd_msr = rd & (reg_addr == ADDR_MSR);

    // ------------------------------------------------------------------
    // Status, trigger level and interrupt identification
    // ------------------------------------------------------------------
    logic             rx_avail, line_err, rx_trig;
    logic [CNT_W-1:0] trig_lvl;
    logic [3:0]       iir_id;
    logic [7:0]       iir_val, lsr_val, msr_val;

    assign rx_avail = (rx_count != '0);
    assign line_err = oe | rx_pe | rx_fe | rx_bi;
    assign rx_trig  = (rx_count >= trig_lvl);

    always_comb begin
        int raw;
        // NOTE: every variable written in a combinational block gets a value on
        // entry, so no path through the block can leave it holding (a latch).
        raw = 1;
        case (fcr_trig)
            2'd0:    raw = 1;
            2'd1:    raw = 4;
            2'd2:    raw = 8;
            default: raw = 14;
        endcase
        trig_lvl = (raw > FIFO_DEPTH) ? CNT_W'(FIFO_DEPTH) : CNT_W'(raw);
    end

    always_comb begin
        iir_id = IID_NONE;
        if (line_err & ier[2])
            iir_id = IID_LINE;
        else if (rx_trig & ier[0])
            iir_id = IID_RXD;
        else if (thre_pend & ier[1])
            iir_id = IID_THRE;
        else if ((dcts | ddsr) & ier[3])
            iir_id = IID_MODEM;
    end

    assign iir_val = {2'b11, 2'b00, iir_id};
    assign lsr_val = {err_fifo, tx_empty, tx_empty, rx_bi, rx_fe, rx_pe, oe, rx_avail};
    assign msr_val = {2'b00, ~dsr_n, ~cts_n, 2'b00, ddsr, dcts};

    // ------------------------------------------------------------------
    // Divisor latch update; a zero result would stall the baud generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cand, div_next;

    always_comb begin
        div_cand = divisor;
        if (wr_dll)
            div_cand[7:0] = reg_wdata[7:0];
        if (wr_dlm)
            div_cand[DIV_W-1:8] = reg_wdata[DIV_W-9:0];
        div_next = (div_cand == '0) ? DIV_W'(1) : div_cand;
    end

    // ------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rdata_mux;

    always_comb begin
        rdata_mux = '0;
        case (reg_addr)
            ADDR_DATA: rdata_mux = dlab     ? DATA_W'(divisor[7:0]) :
                                   rx_avail ? rx_rdata : '0;
            ADDR_IER:  rdata_mux = dlab ? DATA_W'(divisor[DIV_W-1:8]) : DATA_W'(ier);
            ADDR_IIR:  rdata_mux = DATA_W'(iir_val);
            ADDR_LCR:  rdata_mux = DATA_W'(lcr);
            ADDR_MCR:  rdata_mux = DATA_W'(mcr);
            ADDR_LSR:  rdata_mux = DATA_W'(lsr_val);
            ADDR_MSR:  rdata_mux = DATA_W'(msr_val);
            ADDR_SCR:  rdata_mux = DATA_W'(scr);
            default:   rdata_mux = '0;
        endcase
    end

    // THRE pending: rising tx_empty, or enabling the source while already empty.
    // Sticky bits below all let a same-cycle set beat the clear-on-read.
    logic thre_set, thre_clr;
    assign thre_set = (tx_empty & ~tx_empty_q) | (wr_ier & reg_wdata[1] & ~ier[1] & tx_empty);
    assign thre_clr = wr_thr | (rd_iir & (iir_id == IID_THRE));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata   <= '0;
            reg_rvalid  <= 1'b0;
            tx_push     <= 1'b0;
            tx_wdata    <= '0;
            rx_pop      <= 1'b0;
            rx_fifo_rst <= 1'b0;
            tx_fifo_rst <= 1'b0;
            ier         <= '0;
            lcr         <= 8'h03;
            mcr         <= '0;
            fcr_trig    <= '0;
            divisor     <= DIV_RST_V;
            oe          <= 1'b0;
            err_fifo    <= 1'b0;
            dcts        <= 1'b0;
            ddsr        <= 1'b0;
            thre_pend   <= 1'b0;
            cts_q       <= 1'b1;
            dsr_q       <= 1'b1;
            tx_empty_q  <= 1'b1;
            irq         <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            reg_rvalid <= rd;
            if (rd)
                reg_rdata <= rdata_mux;

            tx_push <= wr_thr;
            if (wr_thr)
                tx_wdata <= reg_wdata;
            rx_pop      <= rd_rbr & rx_avail;
            rx_fifo_rst <= wr_fcr & reg_wdata[1];
            tx_fifo_rst <= wr_fcr & reg_wdata[2];

            if (wr_ier) ier      <= reg_wdata[3:0];
            if (wr_lcr) lcr      <= reg_wdata[7:0];
            if (wr_mcr) mcr      <= reg_wdata[4:0];
            if (wr_fcr) fcr_trig <= reg_wdata[7:6];
            if (wr_dll | wr_dlm)
                divisor <= div_next;

            oe        <= rx_overrun | (oe & ~rd_lsr);
            err_fifo  <= ((rx_pe | rx_fe | rx_bi) & rx_avail) | (err_fifo & ~rd_lsr);
            dcts      <= (cts_n ^ cts_q) | (dcts & ~rd_msr);
            ddsr      <= (dsr_n ^ dsr_q) | (ddsr & ~rd_msr);
            thre_pend <= thre_set | (thre_pend & ~thre_clr);

            cts_q      <= cts_n;
            dsr_q      <= dsr_n;
            tx_empty_q <= tx_empty;
            irq        <= ~iir_id[0];
        end
    end

`ifdef UART_SCRATCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scr <= '0;
        else if (wr & (reg_addr == ADDR_SCR))
            scr <= reg_wdata[7:0];
    end
`else
    assign scr = '0;
`endif

    assign lcr_o     = lcr;
    assign divisor_o = divisor;
    assign dtr_n     = ~mcr[0];
    assign rts_n     = ~mcr[1];
    assign loopback  = mcr[4];

endmodule
